regbank16_writeback: RTL
========================

Name: regbank16_writeback

Overview:
- 16-entry x WIDTH register bank with a decoded single write port, two combinational read ports and a per-register busy (pending-write) scoreboard.
- The write-back end of the register file.
- The 4-to-16 write decoder converts a 4-bit index into a one-hot enable.
- Read ports select one of 16 entries by a 4-bit index.
- Sits between the write-back stage (writer) and the decode stage (reader/hazard check) of the 5-stage pipeline.

Parameters:
- WIDTH, 64, data width of each register.
- ZERO_REG, 15, index of the hardwired-zero register (reads 0, writes discarded).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- wr_en  input  1  write request this cycle
- wr_addr  input  4  destination register index
- wr_data  input  WIDTH  write data
- rsv_en  input  1  reserve (mark busy) a destination register
- rsv_addr  input  4  register index to reserve
- rd_addr_a  input  4  read port A index
- rd_addr_b  input  4  read port B index
- rd_data_a  output  WIDTH  read port A data
- rd_data_b  output  WIDTH  read port B data
- busy  output  16  per-register pending-write flags
- wr_ack  output  1  registered acknowledge of an accepted write
- wr_err  output  1  registered flag: write attempted to ZERO_REG

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-low (`reset_n`), sampled on the rising edge of `clk`.
- Reset (reset_n=0 at a rising edge):
  - all 16 registers <= 0, busy <= 16'h0000, wr_ack <= 0, wr_err <= 0.
  - Reset dominates any same-cycle wr_en/rsv_en; that write is lost.
- Write decode:
  - we_onehot = wr_en ? (16'b1 << wr_addr) : 16'b0, with bit ZERO_REG forced 0.
  - Exactly zero or one register updates per edge; reg[i] <= wr_data when we_onehot[i].
- Read ports: combinational, zero cycle latency.
  - rd_data_x = 0 if rd_addr_x == ZERO_REG.
  - Else wr_data if wr_en && wr_addr == rd_addr_x (write-through bypass, same-cycle).
  - Else reg[rd_addr_x].
  - Both ports may address the same register; both return the same value.
- Busy scoreboard, next-state per bit i:
  - set if rsv_en && rsv_addr == i && i != ZERO_REG.
  - else clear if wr_en && wr_addr == i.
  - else hold.
  - Same-cycle reserve and write to the same index: set wins (new producer supersedes retiring one); register data is still updated.
  - Reserving an already-busy register: stays 1.
  - Writing a non-busy register is legal; data is updated, busy stays 0.
  - busy[ZERO_REG] is always 0.
- wr_ack <= wr_en && wr_addr != ZERO_REG. One-cycle pulse per accepted write; back-to-back writes give continuous high.
- wr_err <= wr_en && wr_addr == ZERO_REG. One-cycle pulse; no state change occurs.
- No internal FSM beyond the register/busy state; every input combination is defined above and there are no illegal states.

Test Plan:
- Reset then read all 16 indices on both ports -> every rd_data = 0, busy = 16'h0000, wr_ack = 0, wr_err = 0.
- Write reg[i] = 64'hA5A5_0000_0000_0000 + i for i = 0..14 on consecutive cycles, then read all -> reg[i] matches, wr_ack high for 15 cycles, each write sets exactly one decoded enable (check one-hot).
- wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF, rd_addr_a=3 in the same cycle -> rd_data_a = 64'hDEAD_BEEF combinationally; after the edge, reg[3] holds it.
- wr_en=1, wr_addr=15, wr_data=64'hFFFF_FFFF_FFFF_FFFF -> wr_err=1 next cycle, wr_ack=0, rd_data of 15 stays 0; rsv_addr=15 -> busy stays 16'h0000.
- rsv_en on 5 -> busy=16'h0020. Then wr_en on 5 with rsv_en on 5 in the same cycle -> busy stays 16'h0020. Then wr_en on 5 alone -> busy=16'h0000.
- Load reg[7]=64'h1234, reserve 7, then reset_n=0 with wr_en to 7 in the same cycle -> reg[7]=0, busy=0, wr_ack=0 after the edge.

Source files
------------

// File: rtl/regbank16_writeback.sv
// Write-back end of the 16-entry register file: one decoded write port, two
// bypassing combinational read ports and a per-register pending-write scoreboard.
module regbank16_writeback #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [3:0]       rsv_addr,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [15:0]      busy,
  output logic             wr_ack,
  output logic             wr_err
);

  localparam logic [3:0] ZERO_IDX = 4'(ZERO_REG);

  logic [WIDTH-1:0] regs_r [16];
  logic [15:0]      we_onehot_s;
  logic [15:0]      rsv_onehot_s;
  logic [15:0]      busy_next_s;
  logic [15:0]      busy_r;
  logic             wr_ack_r;
  logic             wr_err_r;
  logic             wr_zero_s;

  assign wr_zero_s = (wr_addr == ZERO_IDX);

  // Decode write and reserve indices to one-hot enables; the zero register never takes either.
  always_comb begin
    we_onehot_s  = 16'h0000;
    rsv_onehot_s = 16'h0000;
    if (wr_en) begin
      we_onehot_s = 16'h0001 << wr_addr;
    end else begin
      we_onehot_s = 16'h0000;
    end
    if (rsv_en) begin
      rsv_onehot_s = 16'h0001 << rsv_addr;
    end else begin
      rsv_onehot_s = 16'h0000;
    end
    we_onehot_s[ZERO_REG]  = 1'b0;
    rsv_onehot_s[ZERO_REG] = 1'b0;
  end

  // Register storage update; reset dominates any same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (we_onehot_s[i]) begin
          regs_r[i] <= wr_data;
        end
      end
    end
  end

  // Scoreboard next state: a new reservation outranks a retiring write to the same register.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < 16; i++) begin
      if (rsv_onehot_s[i]) begin
        busy_next_s[i] = 1'b1;
      end else if (we_onehot_s[i]) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
    busy_next_s[ZERO_REG] = 1'b0;
  end

  // Scoreboard and write-status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r   <= 16'h0000;
      wr_ack_r <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      busy_r   <= busy_next_s;
      wr_ack_r <= wr_en & ~wr_zero_s;
      wr_err_r <= wr_en & wr_zero_s;
    end
  end

  // Read port A with same-cycle write-through so decode sees the retiring value.
  always_comb begin
    rd_data_a = {WIDTH{1'b0}};
    if (rd_addr_a == ZERO_IDX) begin
      rd_data_a = {WIDTH{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
  end

  // Read port B, identical selection rules to port A.
  always_comb begin
    rd_data_b = {WIDTH{1'b0}};
    if (rd_addr_b == ZERO_IDX) begin
      rd_data_b = {WIDTH{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

  assign busy   = busy_r;
  assign wr_ack = wr_ack_r;
  assign wr_err = wr_err_r;

endmodule
